// File: rtl/speed_option_ctrl_pkg.sv
// Shared option encodings for the speed selector and clk_decoder.
package speed_option_ctrl_pkg;

  localparam int unsigned OPT_W = 2;

  localparam logic [OPT_W-1:0] OPT_DIV0 = 2'b00;
  localparam logic [OPT_W-1:0] OPT_DIV1 = 2'b01;
  localparam logic [OPT_W-1:0] OPT_DIV2 = 2'b10;
  localparam logic [OPT_W-1:0] OPT_DIV3 = 2'b11;

endpackage

// File: rtl/btn_debounce.sv
// One active-low push-button: 2-flop synchronizer, stability counter, and a
// registered one-cycle pulse on each accepted press (debounced 1->0).
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press_pulse
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_d, sync_q;
  logic            level_d, level_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            pulse_d, pulse_q;

  always_comb begin
    sync_d  = {sync_q[0], btn_n};
    level_d = level_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      // Level has differed for DEBOUNCE_CYCLES cycles; accept it.
      level_d = sync_q[1];
      cnt_d   = '0;
      pulse_d = ~sync_q[1];
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/speed_option_ctrl.sv
// Up/down push-buttons to the 2-bit usr_option select for clk_decoder, with a
// one-cycle option_changed flag on every accepted change.
module speed_option_ctrl
  import speed_option_ctrl_pkg::*;
#(
  parameter int unsigned      DEBOUNCE_CYCLES = 1000000,
  parameter bit               WRAP            = 1'b1,
  parameter logic [OPT_W-1:0] RESET_OPTION    = OPT_DIV0
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             btn_up_n,
  input  logic             btn_down_n,
  output logic [OPT_W-1:0] usr_option,
  output logic             option_changed
);

  logic             up_pulse, down_pulse;
  logic [OPT_W-1:0] opt_d, opt_q;
  logic             changed_d, changed_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_up (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .btn_n      (btn_up_n),
    .press_pulse(up_pulse)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_down (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .btn_n      (btn_down_n),
    .press_pulse(down_pulse)
  );

  always_comb begin
    opt_d = opt_q;
    // Coincident up and down pulses cancel out.
    if (up_pulse && !down_pulse) begin
      if (opt_q == OPT_DIV3) begin
        opt_d = WRAP ? OPT_DIV0 : OPT_DIV3;
      end else begin
        opt_d = opt_q + 1'b1;
      end
    end else if (down_pulse && !up_pulse) begin
      if (opt_q == OPT_DIV0) begin
        opt_d = WRAP ? OPT_DIV3 : OPT_DIV0;
      end else begin
        opt_d = opt_q - 1'b1;
      end
    end
    changed_d = (opt_d != opt_q);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      opt_q     <= RESET_OPTION;
      changed_q <= 1'b0;
    end else begin
      opt_q     <= opt_d;
      changed_q <= changed_d;
    end
  end

  assign usr_option     = opt_q;
  assign option_changed = changed_q;

endmodule

// File: tb/tb_speed_option_ctrl.sv
// Scoreboard bench: one wrapping and one saturating instance, DEBOUNCE_CYCLES=4.
module tb_speed_option_ctrl;

  typedef struct {
    logic [1:0] val;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       up_w, dn_w, up_s, dn_s;
  logic [1:0] opt_w, opt_s;
  logic       chg_w, chg_s;

  int   cyc;
  int   total;
  int   bad;
  exp_t q_w[$];
  exp_t q_s[$];
  logic [1:0] prev_w, prev_s;

  speed_option_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .WRAP           (1'b1),
    .RESET_OPTION   (2'b00)
  ) dut_w (
    .sys_clk       (clk),
    .rst_n         (rst_n),
    .btn_up_n      (up_w),
    .btn_down_n    (dn_w),
    .usr_option    (opt_w),
    .option_changed(chg_w)
  );

  speed_option_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .WRAP           (1'b0),
    .RESET_OPTION   (2'b00)
  ) dut_s (
    .sys_clk       (clk),
    .rst_n         (rst_n),
    .btn_up_n      (up_s),
    .btn_down_n    (dn_s),
    .usr_option    (opt_s),
    .option_changed(chg_s)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(40 * 5000);
    $display("FAIL watchdog: simulation still running at cyc=%0d, required finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  // Any change of usr_option or any option_changed pulse must match the next
  // expected entry: same value, same cycle, and option_changed set.
  task automatic mon(input int id, input logic [1:0] opt, input logic chg);
    exp_t e;
    logic [1:0] prev;
    prev = (id == 0) ? prev_w : prev_s;
    if (chg || opt != prev) begin
      total++;
      if ((id == 0 && q_w.size() == 0) || (id == 1 && q_s.size() == 0)) begin
        bad++;
        $display("FAIL unexpected_event dut%0d: got opt=%0d chg=%0b at cyc=%0d, required no event",
                 id, opt, chg, cyc);
      end else begin
        e = (id == 0) ? q_w.pop_front() : q_s.pop_front();
        if (opt !== e.val || cyc != e.cyc || chg !== 1'b1) begin
          bad++;
          $display("FAIL option_event dut%0d: got opt=%0d chg=%0b cyc=%0d, required opt=%0d chg=1 cyc=%0d",
                   id, opt, chg, cyc, e.val, e.cyc);
        end
      end
    end
    if (id == 0) prev_w = opt;
    else         prev_s = opt;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_w = 2'b00;
      prev_s = 2'b00;
    end else begin
      mon(0, opt_w, chg_w);
      mon(1, opt_s, chg_s);
    end
  end

  task automatic set_btn(input int id, input bit is_up, input logic v);
    if (id == 0) begin
      if (is_up) up_w = v;
      else       dn_w = v;
    end else begin
      if (is_up) up_s = v;
      else       dn_s = v;
    end
  endtask

  task automatic push(input int id, input logic [1:0] v, input int at);
    exp_t e;
    e.val = v;
    e.cyc = at;
    if (id == 0) q_w.push_back(e);
    else         q_s.push_back(e);
  endtask

  // Clean press: low for hold cycles; update due 7 edges after the drive.
  task automatic press(input int id, input bit is_up, input int hold, input bit expect_evt,
                       input logic [1:0] v);
    @(negedge clk);
    set_btn(id, is_up, 1'b0);
    if (expect_evt) push(id, v, cyc + 7);
    repeat (hold) @(negedge clk);
    set_btn(id, is_up, 1'b1);
    repeat (12) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  initial begin
    int t1;
    total  = 0;
    bad    = 0;
    prev_w = 2'b00;
    prev_s = 2'b00;
    rst_n  = 1'b0;
    up_w = 1'b1; dn_w = 1'b1; up_s = 1'b1; dn_s = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_opt_w", opt_w, 2'b00);
    chk("reset_chg_w", {1'b0, chg_w}, 2'b00);
    chk("reset_opt_s", opt_s, 2'b00);
    chk("reset_chg_s", {1'b0, chg_s}, 2'b00);
    @(negedge clk);
    #5 rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("idle_opt_w", opt_w, 2'b00);
    chk("idle_opt_s", opt_s, 2'b00);

    // Four up presses wrap all the way round.
    press(0, 1'b1, 20, 1'b1, 2'b01);
    press(0, 1'b1, 20, 1'b1, 2'b10);
    press(0, 1'b1, 20, 1'b1, 2'b11);
    press(0, 1'b1, 20, 1'b1, 2'b00);

    // Bouncy down press: 2-cycle toggles, then a steady low.
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      dn_w = (i % 2 == 1);
      repeat (2) @(negedge clk);
    end
    dn_w = 1'b0;
    push(0, 2'b11, cyc + 7);
    repeat (20) @(negedge clk);
    dn_w = 1'b1;
    repeat (12) @(negedge clk);

    // 3-cycle glitch is too short to be accepted.
    @(negedge clk);
    dn_w = 1'b0;
    repeat (3) @(negedge clk);
    dn_w = 1'b1;
    repeat (12) @(negedge clk);

    // Both buttons together: cancelled.
    @(negedge clk);
    up_w = 1'b0;
    dn_w = 1'b0;
    repeat (20) @(negedge clk);
    up_w = 1'b1;
    dn_w = 1'b1;
    repeat (12) @(negedge clk);

    // Up one cycle ahead of down: 3 -> 0 -> 3.
    @(negedge clk);
    up_w = 1'b0;
    push(0, 2'b00, cyc + 7);
    @(negedge clk);
    dn_w = 1'b0;
    push(0, 2'b11, cyc + 7);
    repeat (20) @(negedge clk);
    up_w = 1'b1;
    dn_w = 1'b1;
    repeat (12) @(negedge clk);

    // Saturating instance.
    press(1, 1'b1, 20, 1'b1, 2'b01);
    press(1, 1'b1, 20, 1'b1, 2'b10);
    press(1, 1'b1, 20, 1'b1, 2'b11);
    press(1, 1'b1, 20, 1'b0, 2'b11);
    press(1, 1'b0, 20, 1'b1, 2'b10);
    press(1, 1'b0, 20, 1'b1, 2'b01);
    press(1, 1'b0, 20, 1'b1, 2'b00);
    press(1, 1'b0, 20, 1'b0, 2'b00);
    chk("sat_low_opt_s", opt_s, 2'b00);

    // Reset while up is held with the debounce counter at 2.
    @(negedge clk);
    up_w = 1'b0;
    repeat (4) @(negedge clk);
    #5 rst_n = 1'b0;
    #1;
    chk("midreset_opt_w", opt_w, 2'b00);
    chk("midreset_chg_w", {1'b0, chg_w}, 2'b00);
    @(negedge clk);
    #5 rst_n = 1'b1;
    t1 = cyc;
    push(0, 2'b01, t1 + 7);
    repeat (20) @(negedge clk);
    up_w = 1'b1;
    repeat (12) @(negedge clk);

    total++;
    if (q_w.size() != 0) begin
      bad++;
      $display("FAIL pending_w: %0d expected events never seen, required 0", q_w.size());
    end
    total++;
    if (q_s.size() != 0) begin
      bad++;
      $display("FAIL pending_s: %0d expected events never seen, required 0", q_s.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
